// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate formats, decoded control bundle.
package decode_pkg;

    localparam int INST_W = 32;
    localparam int OPC_W  = 5;
    localparam int REG_W  = 5;
    localparam int F3_W   = 3;

    localparam logic [OPC_W-1:0] OPC_LOAD      = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_AUIPC     = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_STORE     = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_OP        = 5'b01100;
    localparam logic [OPC_W-1:0] OPC_LUI       = 5'b01101;
    localparam logic [OPC_W-1:0] OPC_OP_32     = 5'b01110;
    localparam logic [OPC_W-1:0] OPC_BRANCH    = 5'b11000;
    localparam logic [OPC_W-1:0] OPC_JALR      = 5'b11001;
    localparam logic [OPC_W-1:0] OPC_JAL       = 5'b11011;
    localparam logic [OPC_W-1:0] OPC_SYSTEM    = 5'b11100;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  func3;
        logic             func7;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic             rs1_used;
        logic             rs2_used;
        logic             rd_used;
        logic             illegal;
    } dec_ctrl_t;

    function automatic imm_type_e imm_type_of(logic [OPC_W-1:0] opc);
        imm_type_e t;
        case (opc)
            OPC_LOAD, OPC_OP_IMM,
            OPC_JALR, OPC_OP_IMM_32: t = IMM_I;
            OPC_STORE:               t = IMM_S;
            OPC_BRANCH:              t = IMM_B;
            OPC_LUI, OPC_AUIPC:      t = IMM_U;
            OPC_JAL:                 t = IMM_J;
            default:                 t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: selects format by opcode and
// sign-extends the 32-bit immediate to XLEN.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [31:7]      inst,
    output logic [XLEN-1:0]  imm,
    output imm_type_e        imm_type
);

    logic [31:0] imm32;

    assign imm_type = imm_type_of(opcode);

    always_comb begin
        imm32 = '0;
        unique case (imm_type)
            IMM_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm32 = {{20{inst[31]}}, inst[31:25],
                            inst[11:7]};
            IMM_B: imm32 = {{19{inst[31]}}, inst[31], inst[7],
                            inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm32 = {inst[31:12], 12'b0};
            IMM_J: imm32 = {{11{inst[31]}}, inst[31],
                            inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        imm        = {XLEN{imm32[31]}};
        imm[31:0]  = imm32;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with 2-entry skid buffer and flush.
// Optional legality checking: DECODE_ILLEGAL_CHECK_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [F3_W-1:0]   out_func3,
    output logic              out_func7,
    output logic [REG_W-1:0]  out_rs1,
    output logic [REG_W-1:0]  out_rs2,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_rs1_used,
    output logic              out_rs2_used,
    output logic              out_rd_used,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_illegal
);

    logic [OPC_W-1:0] opc;
    logic [XLEN-1:0]  d_imm;
    imm_type_e        d_ty;
    dec_ctrl_t        d_ctrl;
    logic             illegal;
    logic             is_r;

    assign opc  = in_inst[6:2];
    assign is_r = (opc == OPC_OP) || (opc == OPC_OP_32);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .opcode   (opc),
        .inst     (in_inst[31:7]),
        .imm      (d_imm),
        .imm_type (d_ty)
    );

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic legal_opc;

    always_comb begin
        legal_opc = 1'b0;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_AUIPC,
            OPC_STORE, OPC_OP, OPC_LUI,
            OPC_BRANCH, OPC_JALR, OPC_JAL,
            OPC_MISC_MEM, OPC_SYSTEM:
                legal_opc = 1'b1;
            OPC_OP_IMM_32, OPC_OP_32:
                legal_opc = (XLEN == 64);
            default:
                legal_opc = 1'b0;
        endcase
    end

    assign illegal = (in_inst[1:0] != 2'b11) || !legal_opc;
`else
    logic unused_inst_bits;
    assign unused_inst_bits = ^in_inst[1:0];
    assign illegal = 1'b0;
`endif

    always_comb begin
        d_ctrl          = '0;
        d_ctrl.opcode   = opc;
        d_ctrl.func3    = in_inst[14:12];
        d_ctrl.func7    = in_inst[30];
        d_ctrl.rs1      = in_inst[19:15];
        d_ctrl.rs2      = in_inst[24:20];
        d_ctrl.rd       = in_inst[11:7];
        d_ctrl.illegal  = illegal;
        // U and J formats cover LUI/AUIPC/JAL, the only rs1-free ones
        d_ctrl.rs1_used = !(d_ty == IMM_U || d_ty == IMM_J);
        d_ctrl.rs2_used = is_r || d_ty == IMM_S
                        || d_ty == IMM_B;
        d_ctrl.rd_used  = !(d_ty == IMM_S || d_ty == IMM_B)
                        && (in_inst[11:7] != '0);
        if (illegal) begin
            d_ctrl.rs1_used = 1'b0;
            d_ctrl.rs2_used = 1'b0;
            d_ctrl.rd_used  = 1'b0;
        end
    end

    logic            m_valid;
    dec_ctrl_t       m_ctrl;
    logic [XLEN-1:0] m_imm;
    logic [PC_W-1:0] m_pc;
    logic            s_valid;
    dec_ctrl_t       s_ctrl;
    logic [XLEN-1:0] s_imm;
    logic [PC_W-1:0] s_pc;
    logic            in_acc;
    logic            m_free;

    assign in_ready = !s_valid;
    assign in_acc   = in_valid && in_ready;
    assign m_free   = !m_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_ctrl  <= '0;
            m_imm   <= '0;
            m_pc    <= '0;
            s_ctrl  <= '0;
            s_imm   <= '0;
            s_pc    <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_free) begin
            // in_ready is low whenever S holds, so at most one source
            if (s_valid) begin
                m_valid <= 1'b1;
                m_ctrl  <= s_ctrl;
                m_imm   <= s_imm;
                m_pc    <= s_pc;
                s_valid <= 1'b0;
            end else if (in_acc) begin
                m_valid <= 1'b1;
                m_ctrl  <= d_ctrl;
                m_imm   <= d_imm;
                m_pc    <= in_pc;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (in_acc) begin
            s_valid <= 1'b1;
            s_ctrl  <= d_ctrl;
            s_imm   <= d_imm;
            s_pc    <= in_pc;
        end
    end

    assign out_valid    = m_valid;
    assign out_pc       = m_pc;
    assign out_opcode   = m_ctrl.opcode;
    assign out_func3    = m_ctrl.func3;
    assign out_func7    = m_ctrl.func7;
    assign out_rs1      = m_ctrl.rs1;
    assign out_rs2      = m_ctrl.rs2;
    assign out_rd       = m_ctrl.rd;
    assign out_rs1_used = m_ctrl.rs1_used;
    assign out_rs2_used = m_ctrl.rs2_used;
    assign out_rd_used  = m_ctrl.rd_used;
    assign out_imm      = m_imm;
    assign out_illegal  = m_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus a randomized
// handshake run scored against a queue and an instruction-level model.
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam int XLEN = 32;
`else
    localparam int XLEN = 64;
`endif
    localparam int PC_W = 64;
    localparam int BW   = PC_W + XLEN + 28;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_opcode;
    logic [2:0]      out_func3;
    logic            out_func7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic            out_rs1_used;
    logic            out_rs2_used;
    logic            out_rd_used;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    int n_total = 0;
    int n_pass  = 0;

    logic [BW-1:0] got;
    assign got = {out_pc, out_opcode, out_func3, out_func7,
                  out_rs1, out_rs2, out_rd, out_rs1_used,
                  out_rs2_used, out_rd_used, out_imm, out_illegal};

    logic [4:0] opcs [0:12] = '{5'd0, 5'd3, 5'd4, 5'd5, 5'd6,
                                5'd8, 5'd12, 5'd13, 5'd14,
                                5'd24, 5'd25, 5'd27, 5'd28};

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_func3    (out_func3),
        .out_func7    (out_func7),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_rs1_used (out_rs1_used),
        .out_rs2_used (out_rs2_used),
        .out_rd_used  (out_rd_used),
        .out_imm      (out_imm),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    // Instruction-level reference: immediates as integer arithmetic
    function automatic logic [BW-1:0] model(logic [PC_W-1:0] pc,
                                            logic [31:0] inst);
        longint     si;
        longint     imm;
        bit [63:0]  raw;
        bit [4:0]   opc;
        bit         legal;
        bit         r1;
        bit         r2;
        bit         rdu;
        logic [XLEN-1:0] immx;
        opc = inst[6:2];
        si  = longint'($signed(inst));
        case (opc)
            0, 4, 25, 6: imm = si >>> 20;
            8:  imm = (si >>> 25) * 32 + longint'(inst[11:7]);
            24: imm = (si >>> 31) * 4096
                    + longint'(inst[7]) * 2048
                    + longint'(inst[30:25]) * 32
                    + longint'(inst[11:8]) * 2;
            13, 5: imm = (si >>> 12) * 4096;
            27: imm = (si >>> 31) * 1048576
                    + longint'(inst[19:12]) * 4096
                    + longint'(inst[20]) * 2048
                    + longint'(inst[30:21]) * 2;
            default: imm = 0;
        endcase
        raw  = imm;
        immx = raw[XLEN-1:0];
`ifdef DECODE_ILLEGAL_CHECK_EN
        legal = (inst[1:0] == 2'b11) &&
                ((opc inside {0, 3, 4, 5, 8, 12, 13, 24, 25, 27, 28})
                 || (opc inside {6, 14} && XLEN == 64));
`else
        legal = 1'b1;
`endif
        r1  = !(opc inside {13, 5, 27});
        r2  = opc inside {12, 14, 8, 24};
        rdu = !(opc inside {8, 24}) && (inst[11:7] != 0);
        if (!legal) begin
            r1 = 0;
            r2 = 0;
            rdu = 0;
        end
        return {pc, opc, inst[14:12], inst[30], inst[19:15],
                inst[24:20], inst[11:7], r1, r2, rdu, immx, !legal};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] inst,
                         input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        offer(32'hFFF10093, 64'h1000);
        step();
        step();
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        else n_pass++;
        n_total++;
        if (got !== '0)
            $display("FAIL reset_data got=%h exp=0", got);
        else n_pass++;
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL reset_nothing_accepted got=%b exp=0",
                     out_valid);
        else n_pass++;
    endtask

    task automatic test_addi();
        logic [XLEN-1:0] ones;
        ones = '1;
        out_ready = 1'b1;
        offer(32'hFFF10093, 64'h80);
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL addi_in_ready got=%b exp=1", in_ready);
        else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_rd !== 5'd1 ||
            out_rs1 !== 5'd2 || out_rs2_used !== 1'b0)
            $display("FAIL addi_fields v=%b rd=%0d rs1=%0d rs2u=%b exp 1/1/2/0",
                     out_valid, out_rd, out_rs1, out_rs2_used);
        else n_pass++;
        n_total++;
        if (out_imm !== ones)
            $display("FAIL addi_imm got=%h exp=%h", out_imm, ones);
        else n_pass++;
        n_total++;
        if (got !== model(64'h80, 32'hFFF10093))
            $display("FAIL addi_bundle got=%h exp=%h",
                     got, model(64'h80, 32'hFFF10093));
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL addi_drained got=%b exp=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0]     insts [3];
        logic [XLEN-1:0] eimm [3];
        logic            acc;
        int              k;
        insts[0] = 32'hFE000EE3;
        insts[1] = 32'h00112623;
        insts[2] = 32'h123450B7;
        eimm[0]  = -4;
        eimm[1]  = 12;
        eimm[2]  = 'h12345000;
        out_ready = 1'b0;
        offer(insts[0], 64'h200);
        step();
        offer(insts[1], 64'h204);
        step();
        n_total++;
        if (in_ready !== 1'b0)
            $display("FAIL b2b_in_ready_full got=%b exp=0", in_ready);
        else n_pass++;
        offer(insts[2], 64'h208);
        step();
        n_total++;
        if (in_ready !== 1'b0 || out_pc !== 64'h200)
            $display("FAIL b2b_hold rdy=%b pc=%h exp 0/200",
                     in_ready, out_pc);
        else n_pass++;
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 12 && k < 3; c++) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                n_total++;
                if (got !== model(64'h200 + 4 * k, insts[k]))
                    $display("FAIL b2b_bundle%0d got=%h exp=%h", k, got,
                             model(64'h200 + 4 * k, insts[k]));
                else n_pass++;
                n_total++;
                if (out_imm !== eimm[k])
                    $display("FAIL b2b_imm%0d got=%h exp=%h",
                             k, out_imm, eimm[k]);
                else n_pass++;
                k++;
            end
            step();
            if (acc) in_valid = 1'b0;
        end
        n_total++;
        if (k != 3)
            $display("FAIL b2b_timeout got=%0d bundles exp=3", k);
        else n_pass++;
    endtask

    task automatic test_flush();
        int seen;
        out_ready = 1'b0;
        offer(32'h00500113, 64'h300);
        step();
        offer(32'h00600193, 64'h304);
        step();
        offer(32'h00700213, 64'h308);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_full v=%b rdy=%b exp 0/1",
                     out_valid, in_ready);
        else n_pass++;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) seen++;
            step();
        end
        n_total++;
        if (seen != 0)
            $display("FAIL flush_ghost got=%0d bundles exp=0", seen);
        else n_pass++;
        out_ready = 1'b0;
        offer(32'h00800293, 64'h400);
        step();
        offer(32'h00900313, 64'h404);
        out_ready = 1'b1;
        flush = 1'b1;
        n_total++;
        if (in_ready !== 1'b1)
            $display("FAIL flush_offer_ready got=%b exp=1", in_ready);
        else n_pass++;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL flush_drop_input got=%b exp=0", out_valid);
        else n_pass++;
        offer(32'h00A00393, 64'h408);
        step();
        in_valid = 1'b0;
        n_total++;
        if (got !== model(64'h408, 32'h00A00393))
            $display("FAIL flush_resume got=%h exp=%h",
                     got, model(64'h408, 32'h00A00393));
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL flush_resume_drain got=%b exp=0", out_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [PC_W+31:0] q [$];
        logic [PC_W+31:0] e;
        logic [31:0]      inst;
        int               errs;
        errs = 0;
        for (int c = 0; c < 1000; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            inst = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                inst[1:0] = 2'b11;
                inst[6:2] = opcs[$urandom_range(0, 12)];
            end
            in_inst   = inst;
            in_pc     = {$urandom, $urandom};
            out_ready = $urandom_range(0, 1);
            if (in_valid && in_ready) q.push_back({in_pc, in_inst});
            if (out_valid && out_ready) begin
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL rand_dup got=%h exp=none", got);
                end else begin
                    e = q.pop_front();
                    if (got !== model(e[PC_W+31:32], e[31:0]))
                        $display("FAIL rand_bundle got=%h exp=%h", got,
                                 model(e[PC_W+31:32], e[31:0]));
                    else n_pass++;
                end
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            if (out_valid) begin
                e = q.pop_front();
                n_total++;
                if (got !== model(e[PC_W+31:32], e[31:0]))
                    $display("FAIL rand_drain got=%h exp=%h", got,
                             model(e[PC_W+31:32], e[31:0]));
                else n_pass++;
            end
            step();
        end
        n_total++;
        if (q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL rand_loss left=%0d v=%b exp 0/0",
                     q.size(), out_valid);
        else n_pass++;
    endtask

`ifdef DECODE_ILLEGAL_CHECK_EN
    task automatic test_illegal();
        logic [31:0] insts [3];
        logic        eill [3];
        insts[0] = 32'h0000001B;
        insts[1] = 32'h00000000;
        insts[2] = 32'hFFF10093;
        eill[0]  = 1'b1;
        eill[1]  = 1'b1;
        eill[2]  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(insts[i], 64'h500);
            step();
            in_valid = 1'b0;
            n_total++;
            if (out_valid !== 1'b1 || out_illegal !== eill[i])
                $display("FAIL illegal%0d v=%b ill=%b exp 1/%b",
                         i, out_valid, out_illegal, eill[i]);
            else n_pass++;
            if (eill[i]) begin
                n_total++;
                if ({out_rs1_used, out_rs2_used, out_rd_used} !== 3'b0)
                    $display("FAIL illegal_flags%0d got=%b exp=000", i,
                             {out_rs1_used, out_rs2_used, out_rd_used});
                else n_pass++;
            end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_flush();
`ifdef DECODE_ILLEGAL_CHECK_EN
        test_illegal();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage between fetch and execute.
- Generalises the combinational field splitter: XLEN-parametrised (RV32I/RV64I), adds sign-extended immediate generation and register-use flags.
- Adds a valid/ready handshake with a 2-entry skid buffer so in_ready is a register output, plus flush.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. Sets immediate width and whether the OP-IMM-32/OP-32 opcodes are legal.
- PC_W, 64, width of the program-counter sideband carried alongside the instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all held instructions (branch redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_inst  in  32  raw instruction.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  PC_W  PC of the bundle.
- out_opcode  out  5  inst[6:2].
- out_func3  out  3  inst[14:12].
- out_func7  out  1  inst[30].
- out_rs1  out  5  inst[19:15].
- out_rs2  out  5  inst[24:20].
- out_rd  out  5  inst[11:7].
- out_rs1_used, out_rs2_used, out_rd_used  out  1 each  register actually read or written by this format.
- out_imm  out  XLEN  sign-extended immediate.
- out_illegal  out  1  unsupported opcode (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge): both entries invalid; out_valid=0; in_ready=1; all data outputs 0.
- Storage: main entry M drives the outputs; skid entry S. in_ready = !S.valid.
- Input handshake: a transfer occurs when in_valid && in_ready. Output handshake: a transfer occurs when out_valid && out_ready.
- Latency: an instruction accepted at edge N is presented at out_* from just after edge N (out_valid=1 in cycle N+1) if M is empty or consumed at the same edge.
- Accept with M empty or draining: the instruction loads into M.
- Accept with M held (out_ready=0): the instruction loads into S; in_ready falls next cycle.
- When M drains and S is valid: S moves into M, S clears, in_ready rises next cycle.
- Ordering is strictly FIFO; no drop and no duplication under any ready/valid pattern.
- Decode is computed at load time, so only registered values reach the outputs.
- Immediate selection by opcode[4:0]:
  - I-type (00000 LOAD, 00100 OP-IMM, 11001 JALR, 00110 OP-IMM-32): inst[31:20].
  - S-type (01000): {inst[31:25], inst[11:7]}.
  - B-type (11000): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type (01101 LUI, 00101 AUIPC): {inst[31:12], 12'b0}.
  - J-type (11011): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All immediates are sign-extended from their top bit to XLEN. Every other opcode gives imm=0.
- Register-use flags:
  - rs1_used = 0 for LUI, AUIPC, JAL.
  - rs2_used = 1 only for OP, OP-32, STORE, BRANCH.
  - rd_used = 0 for STORE, BRANCH, and when rd=0.
- Flush: at the edge where flush=1, M and S are invalidated, out_valid=0 and in_ready=1 next cycle.
  - An input offered in the same cycle is dropped.
  - An output handshake in the same cycle still counts as consumed by execute.
- Flush or reset has priority over every other event.

Optional Feature:
- Macro DECODE_ILLEGAL_CHECK_EN.
- Defined: out_illegal=1 when any of the following holds:
  - inst[1:0] != 2'b11;
  - opcode is not in {LOAD, OP-IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, MISC-MEM, SYSTEM};
  - opcode is OP-IMM-32/OP-32 and XLEN==32.
- When out_illegal=1, the use flags are forced to 0.
- Undefined: out_illegal is tied to 0 and no legality logic is synthesised.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams (OPC_LOAD=5'b00000, etc.);
  - imm-type enum IMM_I/S/B/U/J/NONE;
  - the decoded-bundle field widths.
- One natural sub-module: imm_gen (combinational, XLEN parameter; inst -> imm, imm type). It is instantiated once, on the input side.

Test Plan:
- Reset with rst_n=0 for 2 cycles while in_valid=1 -> out_valid=0, in_ready=1; nothing accepted.
- 0xFFF10093 (addi x1,x2,-1) at XLEN=64 with out_ready=1 -> next cycle out_valid=1, out_rd=1, out_rs1=2, out_rs2_used=0, out_imm=0xFFFFFFFFFFFFFFFF.
- Back-to-back beq 0xFE000EE3, sw 0x00112623, lui 0x123450B7 with out_ready=0 for 3 cycles:
  - in_ready=0 after the 2nd accept;
  - after release, bundles emerge in order;
  - beq imm=-4, sw imm=12, lui imm=0x12345000.
- flush asserted while M and S are both full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed and offered instructions never appear.
- Toggle out_ready randomly for 1000 cycles with random in_valid -> scoreboard shows no loss, duplication or reordering.
- With DECODE_ILLEGAL_CHECK_EN, XLEN=32: 0x0000001B (addiw) -> out_illegal=1; 0x00000000 -> out_illegal=1; addi -> out_illegal=0.
